// File: rtl/q100_dtcm_arbiter.sv
// q100_dtcm_arbiter: shares the single DTCM port between the core MEM stage
// (fixed priority) and a loader/debug DMA master that uses idle cycles. A
// starvation counter opens a bounded DMA window during which the core stalls.
// Optional statistics counters are built when Q100_DTCM_ARB_STATS_EN is defined.
module q100_dtcm_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int BANK_N     = 4,
  parameter int STARVE_MAX = 8,
  parameter int DMA_WINDOW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [BANK_N-1:0] core_we_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  input  logic              dma_req_i,
  output logic              dma_gnt_o,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [BANK_N-1:0] dma_we_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic [ADDR_W-1:0] dtcm_addr_o,
  output logic [BANK_N-1:0] dtcm_we_o,
  output logic [DATA_W-1:0] dtcm_data_o,
  input  logic [DATA_W-1:0] dtcm_data_i
`ifdef Q100_DTCM_ARB_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [31:0]       stat_core_beats_o,
  output logic [31:0]       stat_dma_beats_o,
  output logic [31:0]       stat_stall_cycles_o
`endif
);

  localparam int STARVE_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam int WIN_W    = (DMA_WINDOW > 1) ? $clog2(DMA_WINDOW) : 1;

  typedef enum logic [0:0] {
    S_CORE = 1'b0,
    S_DMA  = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [STARVE_W-1:0] starve_r;
  logic [STARVE_W-1:0] starve_s;
  logic [WIN_W-1:0]    win_r;
  logic [WIN_W-1:0]    win_s;
  logic                sel_core_s;
  logic                sel_dma_s;
  logic                rd_pend_r;
  logic [DATA_W-1:0]   rdata_hold_r;

  // Next-state, requester selection and starvation/window counter decode
  always_comb begin
    state_s    = state_r;
    starve_s   = starve_r;
    win_s      = win_r;
    sel_core_s = 1'b0;
    sel_dma_s  = 1'b0;
    case (state_r)
      S_CORE: begin
        if (core_req_i) begin
          sel_core_s = 1'b1;
          if (dma_req_i) begin
            if (starve_r == STARVE_W'(STARVE_MAX - 1)) begin
              state_s  = S_DMA;
              win_s    = {WIN_W{1'b0}};
              starve_s = {STARVE_W{1'b0}};
            end else begin
              starve_s = starve_r + STARVE_W'(1);
            end
          end else begin
            starve_s = {STARVE_W{1'b0}};
          end
        end else begin
          sel_dma_s = dma_req_i;
          starve_s  = {STARVE_W{1'b0}};
        end
      end
      S_DMA: begin
        if (dma_req_i) begin
          sel_dma_s = 1'b1;
          win_s     = win_r + WIN_W'(1);
          if (win_r == WIN_W'(DMA_WINDOW - 1)) begin
            state_s = S_CORE;
          end else begin
            state_s = S_DMA;
          end
        end else begin
          state_s = S_CORE;
        end
      end
      default: begin
        state_s  = S_CORE;
        starve_s = {STARVE_W{1'b0}};
        win_s    = {WIN_W{1'b0}};
      end
    endcase
  end

  // Stall comes straight from the state register so it never glitches
  assign core_stall_o = (state_r == S_DMA);
  assign dma_gnt_o    = sel_dma_s;

  // With no selection the port performs a harmless read at the core address
  assign dtcm_addr_o  = sel_dma_s ? dma_addr_i : core_addr_i;
  assign dtcm_we_o    = sel_dma_s ? dma_we_i : (sel_core_s ? core_we_i : {BANK_N{1'b0}});
  assign dtcm_data_o  = sel_dma_s ? dma_wdata_i : core_wdata_i;
  assign core_rdata_o = dtcm_data_i;

  // DMA read data is live in the return cycle, then held until the next DMA read
  assign dma_rvalid_o = rd_pend_r;
  assign dma_rdata_o  = rd_pend_r ? dtcm_data_i : rdata_hold_r;

  // Arbitration state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_CORE;
      starve_r <= {STARVE_W{1'b0}};
      win_r    <= {WIN_W{1'b0}};
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
      win_r    <= win_s;
    end
  end

  // DMA read-return tracking and read-data hold register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_r    <= 1'b0;
      rdata_hold_r <= {DATA_W{1'b0}};
    end else begin
      rd_pend_r <= sel_dma_s && (dma_we_i == {BANK_N{1'b0}});
      if (rd_pend_r) begin
        rdata_hold_r <= dtcm_data_i;
      end
    end
  end

`ifdef Q100_DTCM_ARB_STATS_EN
  logic [31:0] stat_core_r;
  logic [31:0] stat_dma_r;
  logic [31:0] stat_stall_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    if (en && (val != 32'hFFFF_FFFF)) begin
      return val + 32'd1;
    end else begin
      return val;
    end
  endfunction

  // Saturating usage counters; a clear pulse wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_core_r  <= 32'd0;
      stat_dma_r   <= 32'd0;
      stat_stall_r <= 32'd0;
    end else if (stat_clr_i) begin
      stat_core_r  <= 32'd0;
      stat_dma_r   <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      stat_core_r  <= sat_inc(stat_core_r, sel_core_s);
      stat_dma_r   <= sat_inc(stat_dma_r, sel_dma_s);
      stat_stall_r <= sat_inc(stat_stall_r, core_stall_o);
    end
  end

  assign stat_core_beats_o   = stat_core_r;
  assign stat_dma_beats_o    = stat_dma_r;
  assign stat_stall_cycles_o = stat_stall_r;
`endif

endmodule

// File: tb/tb_q100_dtcm_arbiter.sv
// Self-checking bench for q100_dtcm_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model and memory.
module tb_q100_dtcm_arbiter;
  localparam int STARVE_MAX = 8;
  localparam int DMA_WINDOW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i;
  logic [15:0] core_addr_i;
  logic [3:0]  core_we_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        core_stall_o;
  logic        dma_req_i;
  logic        dma_gnt_o;
  logic [15:0] dma_addr_i;
  logic [3:0]  dma_we_i;
  logic [31:0] dma_wdata_i;
  logic        dma_rvalid_o;
  logic [31:0] dma_rdata_o;
  logic [15:0] dtcm_addr_o;
  logic [3:0]  dtcm_we_o;
  logic [31:0] dtcm_data_o;
  logic [31:0] dtcm_data_i;
  bit          clr_next;
`ifdef Q100_DTCM_ARB_STATS_EN
  logic        stat_clr_i;
  logic [31:0] stat_core_beats_o;
  logic [31:0] stat_dma_beats_o;
  logic [31:0] stat_stall_cycles_o;
`endif

  q100_dtcm_arbiter #(
    .ADDR_W(16), .DATA_W(32), .BANK_N(4),
    .STARVE_MAX(STARVE_MAX), .DMA_WINDOW(DMA_WINDOW)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_wdata_i(core_wdata_i), .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
    .dma_req_i(dma_req_i), .dma_gnt_o(dma_gnt_o), .dma_addr_i(dma_addr_i),
    .dma_we_i(dma_we_i), .dma_wdata_i(dma_wdata_i), .dma_rvalid_o(dma_rvalid_o),
    .dma_rdata_o(dma_rdata_o), .dtcm_addr_o(dtcm_addr_o), .dtcm_we_o(dtcm_we_o),
    .dtcm_data_o(dtcm_data_o), .dtcm_data_i(dtcm_data_i)
`ifdef Q100_DTCM_ARB_STATS_EN
    ,
    .stat_clr_i(stat_clr_i), .stat_core_beats_o(stat_core_beats_o),
    .stat_dma_beats_o(stat_dma_beats_o), .stat_stall_cycles_o(stat_stall_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  // DTCM macro model: byte-lane writes, registered read with one-cycle latency
  logic [31:0] mem [0:255];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dtcm_we_o[b]) mem[dtcm_addr_o[7:0]][b*8 +: 8] <= dtcm_data_o[b*8 +: 8];
    end
    dtcm_data_i <= mem[dtcm_addr_o[7:0]];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: shadow memory plus window/denial bookkeeping in plain integers
  logic [31:0] ref_mem [0:255];
  int          m_left;       // DMA beats still owed in a forced window (0 = no window)
  int          m_denied;     // consecutive contended cycles the DMA lost
  bit          m_pend_rd;
  logic [31:0] m_pend_data;
  bit          m_core_pend;
  logic [31:0] m_core_data;
  logic [31:0] m_rdata_hold;

  bit          e_stall, e_gnt, e_rvalid, e_core_valid;
  logic [31:0] e_rdata, e_core_rdata, e_wdata;
  logic [15:0] e_addr;
  logic [3:0]  e_we;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_left = 0; m_denied = 0; m_pend_rd = 0; m_core_pend = 0; m_rdata_hold = 32'd0;
  endtask

  // Apply one cycle of inputs at the falling edge and compute expected outputs
  task automatic step(input bit cr, input logic [15:0] ca, input logic [3:0] cwe,
                      input logic [31:0] cwd, input bit dr, input logic [15:0] da,
                      input logic [3:0] dwe, input logic [31:0] dwd);
    bit core_served;
    @(negedge clk);
    core_req_i = cr; core_addr_i = ca; core_we_i = cwe; core_wdata_i = cwd;
    dma_req_i = dr; dma_addr_i = da; dma_we_i = dwe; dma_wdata_i = dwd;
`ifdef Q100_DTCM_ARB_STATS_EN
    stat_clr_i = clr_next;
`endif
    #1;
    e_stall = (m_left > 0);
    e_rvalid = m_pend_rd;
    if (m_pend_rd) m_rdata_hold = m_pend_data;
    e_rdata = m_rdata_hold;
    e_core_valid = m_core_pend;
    e_core_rdata = m_core_data;
    core_served = 0;
    e_gnt = 0;
    if (m_left > 0) begin
      e_gnt = dr;
      if (dr) m_left = m_left - 1; else m_left = 0;
    end else if (cr) begin
      core_served = 1;
      if (dr) begin
        m_denied = m_denied + 1;
        if (m_denied == STARVE_MAX) begin
          m_left = DMA_WINDOW;
          m_denied = 0;
        end
      end else m_denied = 0;
    end else begin
      e_gnt = dr;
      m_denied = 0;
    end
    if (e_gnt) begin
      e_addr = da; e_we = dwe; e_wdata = dwd;
    end else if (core_served) begin
      e_addr = ca; e_we = cwe; e_wdata = cwd;
    end else begin
      e_addr = ca; e_we = 4'h0; e_wdata = cwd;
    end
    m_pend_rd = e_gnt && (dwe == 4'h0);
    m_pend_data = ref_mem[da[7:0]];
    m_core_pend = core_served && (cwe == 4'h0);
    m_core_data = ref_mem[ca[7:0]];
    if (e_gnt && dwe != 4'h0) ref_mem[da[7:0]] = merge(ref_mem[da[7:0]], dwd, dwe);
    if (core_served && cwe != 4'h0) ref_mem[ca[7:0]] = merge(ref_mem[ca[7:0]], cwd, cwe);
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 4'h0, 32'd0, 1'b0, 16'h0000, 4'h0, 32'd0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (core_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", core_stall_o); end
    checks++; if (dma_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", dma_rvalid_o); end
    checks++; if (dma_rdata_o !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", dma_rdata_o); end
    checks++; if (dma_gnt_o !== 1'b0 || dtcm_we_o !== 4'h0) begin failures++; $display("FAIL reset_nogrant gnt=%b we=%h exp 0/0", dma_gnt_o, dtcm_we_o); end
`ifdef Q100_DTCM_ARB_STATS_EN
    checks++; if (stat_core_beats_o !== 32'd0 || stat_dma_beats_o !== 32'd0 || stat_stall_cycles_o !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_core_beats_o, stat_dma_beats_o, stat_stall_cycles_o); end
`endif
    @(negedge clk); rst = 1'b1;
    model_reset();
  endtask

  task automatic test_dma_write_read();
    step(1'b0, 16'h0000, 4'h0, 32'd0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    checks++; if (dma_gnt_o !== 1'b1 || dtcm_we_o !== 4'hF || dtcm_addr_o !== 16'h0010 || dtcm_data_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL dma_write gnt=%b we=%h addr=%h data=%h exp 1/f/0010/deadbeef", dma_gnt_o, dtcm_we_o, dtcm_addr_o, dtcm_data_o); end
    step(1'b0, 16'h0000, 4'h0, 32'd0, 1'b1, 16'h0010, 4'h0, 32'd0);
    checks++; if (dma_gnt_o !== 1'b1 || dtcm_we_o !== 4'h0) begin
      failures++; $display("FAIL dma_read_gnt gnt=%b we=%h exp 1/0", dma_gnt_o, dtcm_we_o); end
    idle();
    checks++; if (dma_rvalid_o !== 1'b1 || dma_rdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL dma_read_ret rvalid=%b rdata=%h exp 1/deadbeef", dma_rvalid_o, dma_rdata_o); end
    idle();
    checks++; if (dma_rvalid_o !== 1'b0 || dma_rdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL dma_read_hold rvalid=%b rdata=%h exp 0/deadbeef", dma_rvalid_o, dma_rdata_o); end
  endtask

  task automatic test_starvation_pattern();
    int period;
    period = STARVE_MAX + DMA_WINDOW;
    for (int i = 0; i < 2 * period; i++) begin
      bit exp_win;
      step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b1, 16'h0031, 4'hF, 32'(i));
      exp_win = (i % period) >= STARVE_MAX;
      checks++; if (core_stall_o !== exp_win || dma_gnt_o !== exp_win) begin
        failures++; $display("FAIL starve_pattern cyc=%0d stall=%b gnt=%b exp=%b/%b", i, core_stall_o, dma_gnt_o, exp_win, exp_win); end
    end
    idle();
  endtask

  task automatic test_window_early_exit();
    for (int i = 0; i < STARVE_MAX; i++) step(1'b1, 16'h0010, 4'h0, 32'd0, 1'b1, 16'h0040, 4'hF, 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'h0010, 4'h0, 32'd0, 1'b1, 16'h0040, 4'hF, 32'hB0B0_0000 + 32'(i));
      checks++; if (core_stall_o !== 1'b1 || dma_gnt_o !== 1'b1) begin
        failures++; $display("FAIL early_win_beat%0d stall=%b gnt=%b exp 1/1", i, core_stall_o, dma_gnt_o); end
    end
    step(1'b1, 16'h0010, 4'h0, 32'd0, 1'b0, 16'h0040, 4'h0, 32'd0);
    checks++; if (core_stall_o !== 1'b1 || dma_gnt_o !== 1'b0 || dtcm_we_o !== 4'h0) begin
      failures++; $display("FAIL early_drop stall=%b gnt=%b we=%h exp 1/0/0", core_stall_o, dma_gnt_o, dtcm_we_o); end
    step(1'b1, 16'h0010, 4'h0, 32'd0, 1'b0, 16'h0040, 4'h0, 32'd0);
    checks++; if (core_stall_o !== 1'b0 || dtcm_addr_o !== 16'h0010) begin
      failures++; $display("FAIL early_core_back stall=%b addr=%h exp 0/0010", core_stall_o, dtcm_addr_o); end
    idle();
    checks++; if (core_rdata_o !== 32'hDEADBEEF) begin
      failures++; $display("FAIL early_core_rdata got=%h exp=deadbeef", core_rdata_o); end
  endtask

  task automatic test_core_read_contended();
    step(1'b0, 16'h0000, 4'h0, 32'd0, 1'b1, 16'h0020, 4'hF, 32'h12345678);
    step(1'b1, 16'h0020, 4'h0, 32'd0, 1'b1, 16'h0050, 4'h0, 32'd0);
    checks++; if (dma_gnt_o !== 1'b0 || dtcm_we_o !== 4'h0 || dtcm_addr_o !== 16'h0020 || core_stall_o !== 1'b0) begin
      failures++; $display("FAIL contend_core gnt=%b we=%h addr=%h stall=%b exp 0/0/0020/0", dma_gnt_o, dtcm_we_o, dtcm_addr_o, core_stall_o); end
    step(1'b0, 16'h0000, 4'h0, 32'd0, 1'b1, 16'h0050, 4'h0, 32'd0);
    checks++; if (core_rdata_o !== 32'h12345678) begin
      failures++; $display("FAIL contend_core_rdata got=%h exp=12345678", core_rdata_o); end
    idle();
    idle();
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < STARVE_MAX; i++) step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b1, 16'h0010, 4'h0, 32'd0);
    step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b1, 16'h0010, 4'h0, 32'd0);
    checks++; if (core_stall_o !== 1'b1 || dma_gnt_o !== 1'b1) begin
      failures++; $display("FAIL rstwin_setup stall=%b gnt=%b exp 1/1", core_stall_o, dma_gnt_o); end
    rst = 1'b0; core_req_i = 1'b0; dma_req_i = 1'b0;
    model_reset();
    #1;
    checks++; if (core_stall_o !== 1'b0 || dma_rvalid_o !== 1'b0 || dma_rdata_o !== 32'd0) begin
      failures++; $display("FAIL rstwin_immediate stall=%b rvalid=%b rdata=%h exp 0/0/0", core_stall_o, dma_rvalid_o, dma_rdata_o); end
    @(posedge clk); #2;
    checks++; if (dma_rvalid_o !== 1'b0) begin
      failures++; $display("FAIL rstwin_dropped rvalid=%b exp=0", dma_rvalid_o); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i <= STARVE_MAX; i++) begin
      bit exp_stall;
      step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b1, 16'h0010, 4'h0, 32'd0);
      exp_stall = (i == STARVE_MAX);
      checks++; if (core_stall_o !== exp_stall || dma_rvalid_o !== 1'b0) begin
        failures++; $display("FAIL rstwin_restart cyc=%0d stall=%b rvalid=%b exp %b/0", i, core_stall_o, dma_rvalid_o, exp_stall); end
    end
    for (int i = 0; i < DMA_WINDOW + 2; i++) idle();
  endtask

  task automatic test_random();
    bit cr, dr;
    logic [15:0] ca, da;
    logic [3:0] cwe, dwe;
    logic [31:0] cwd, dwd;
    cr = 0; dr = 0; ca = 16'h0; da = 16'h0; cwe = 4'h0; dwe = 4'h0; cwd = 32'd0; dwd = 32'd0;
    for (int i = 0; i < 400; i++) begin
      step(cr, ca, cwe, cwd, dr, da, dwe, dwd);
      checks++; if (core_stall_o !== e_stall || dma_gnt_o !== e_gnt) begin
        failures++; $display("FAIL rnd_arb cyc=%0d stall=%b gnt=%b exp %b/%b", i, core_stall_o, dma_gnt_o, e_stall, e_gnt); end
      checks++; if (dtcm_addr_o !== e_addr || dtcm_we_o !== e_we || (e_we != 4'h0 && dtcm_data_o !== e_wdata)) begin
        failures++; $display("FAIL rnd_port cyc=%0d addr=%h we=%h data=%h exp %h/%h/%h", i, dtcm_addr_o, dtcm_we_o, dtcm_data_o, e_addr, e_we, e_wdata); end
      checks++; if (dma_rvalid_o !== e_rvalid || dma_rdata_o !== e_rdata) begin
        failures++; $display("FAIL rnd_dma_ret cyc=%0d rvalid=%b rdata=%h exp %b/%h", i, dma_rvalid_o, dma_rdata_o, e_rvalid, e_rdata); end
      if (e_core_valid) begin
        checks++; if (core_rdata_o !== e_core_rdata) begin
          failures++; $display("FAIL rnd_core_rdata cyc=%0d got=%h exp=%h", i, core_rdata_o, e_core_rdata); end
      end
      if (!(cr && e_stall)) begin
        cr = ($urandom_range(0, 3) != 0);
        ca = 16'($urandom_range(0, 15));
        cwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        cwd = $urandom;
      end
      if (!(dr && e_gnt)) begin
        if (!dr) begin
          dr = ($urandom_range(0, 2) != 0);
          da = 16'($urandom_range(0, 15));
          dwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
          dwd = $urandom;
        end
      end else begin
        dr = ($urandom_range(0, 2) != 0);
        da = 16'($urandom_range(0, 15));
        dwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
        dwd = $urandom;
      end
    end
    for (int i = 0; i < DMA_WINDOW + 2; i++) idle();
  endtask

`ifdef Q100_DTCM_ARB_STATS_EN
  task automatic test_stats();
    clr_next = 1;
    step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b0, 16'h0000, 4'h0, 32'd0);
    clr_next = 0;
    for (int i = 0; i < 24; i++) step(1'b1, 16'h0030, 4'h0, 32'd0, 1'b1, 16'h0031, 4'hF, 32'(i));
    idle();
    checks++; if (stat_core_beats_o !== 32'd16 || stat_dma_beats_o !== 32'd8 || stat_stall_cycles_o !== 32'd8) begin
      failures++; $display("FAIL stats_count got=%0d/%0d/%0d exp=16/8/8", stat_core_beats_o, stat_dma_beats_o, stat_stall_cycles_o); end
    clr_next = 1;
    idle();
    clr_next = 0;
    idle();
    checks++; if (stat_core_beats_o !== 32'd0 || stat_dma_beats_o !== 32'd0 || stat_stall_cycles_o !== 32'd0) begin
      failures++; $display("FAIL stats_clear got=%0d/%0d/%0d exp=0/0/0", stat_core_beats_o, stat_dma_beats_o, stat_stall_cycles_o); end
  endtask
`endif

  initial begin
    rst = 1'b0; mem_clr = 1'b1; clr_next = 0;
    core_req_i = 1'b0; core_addr_i = 16'h0; core_we_i = 4'h0; core_wdata_i = 32'd0;
    dma_req_i = 1'b0; dma_addr_i = 16'h0; dma_we_i = 4'h0; dma_wdata_i = 32'd0;
`ifdef Q100_DTCM_ARB_STATS_EN
    stat_clr_i = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    test_reset();
    test_dma_write_read();
    test_starvation_pattern();
    test_window_early_exit();
    test_core_read_contended();
    test_reset_mid_window();
    test_random();
`ifdef Q100_DTCM_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
